// File: rtl/gray_conv_sched_pkg.sv
// ============================================================================
// Module   : gray_sched_pkg
// Brief    : Shared widths, source ids and in-flight tag type for gray_conv_sched.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_sched_pkg;

  localparam int PIX_W = 8;

  localparam logic SRC_LEFT  = 1'b0;
  localparam logic SRC_RIGHT = 1'b1;

  typedef struct packed {
    logic valid;
    logic src;
  } tag_t;

  function automatic logic other_src(input logic src);
    return (src == SRC_LEFT) ? SRC_RIGHT : SRC_LEFT;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gray_conv_sched_if.sv
// ============================================================================
// Module   : gray_conv_sched_if
// Brief    : RGB pixel stream with valid/ready handshake from one camera source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gray_conv_sched_if;
  import gray_sched_pkg::*;

  logic [PIX_W-1:0] red;
  logic [PIX_W-1:0] green;
  logic [PIX_W-1:0] blue;
  logic             valid;
  logic             ready;

  modport master (output red, green, blue, valid, input ready);
  modport slave  (input red, green, blue, valid, output ready);

endinterface

`default_nettype wire

// File: rtl/gray_conv_sched_rr_arb2.sv
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin arbiter; grant is combinational on requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2
  import gray_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_grant,
  output logic       o_grant_src,
  output logic       o_any_grant
);

  logic r_ptr;

  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (r_ptr == SRC_RIGHT) ? 2'b10 : 2'b01;
      default: o_grant = 2'b00;
    endcase
  end

  assign o_grant_src = o_grant[1] ? SRC_RIGHT : SRC_LEFT;
  assign o_any_grant = |o_grant;

  // Any grant hands priority to the other source, contested or not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= SRC_LEFT;
    end else if (o_any_grant) begin
      r_ptr <= other_src(o_grant_src);
    end
  end

endmodule

`default_nettype wire

// File: rtl/gray_conv_sched.sv
// ============================================================================
// Module   : gray_conv_sched
// Brief    : Shares one rgb2gray converter between two pixel streams, tags
//            in-flight pixels, routes results back and counts frame pixels.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_conv_sched
  import gray_sched_pkg::*;
#(
  parameter int CONV_LATENCY = 1,
  parameter int FRAME_PIXELS = 307200,
  parameter int CNT_W        = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_i,
  gray_conv_sched_if.slave  s0,
  gray_conv_sched_if.slave  s1,
  output logic [PIX_W-1:0]  conv_red_o,
  output logic [PIX_W-1:0]  conv_green_o,
  output logic [PIX_W-1:0]  conv_blue_o,
  output logic              conv_done_o,
  input  logic [PIX_W-1:0]  conv_gray_i,
  input  logic              conv_done_i,
  output logic [PIX_W-1:0]  gray_o,
  output logic              gray_valid_o,
  output logic              gray_src_o,
  output logic [1:0]        frame_done_o,
  output logic              idle_o,
  output logic              err_o
);

  localparam logic [CNT_W-1:0] c_last_pix = CNT_W'(FRAME_PIXELS - 1);

  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic       w_grant_src;
  logic       w_any_grant;

  logic       r_issue_src;
  tag_t       r_tag [CONV_LATENCY];
  tag_t       w_tail;
  logic       w_tags_busy;
  logic       w_collect;
  logic       w_mismatch;

  logic [CNT_W-1:0] r_cnt [2];

  // Requests are masked while in reset so no ready can escape during rst.
  assign w_req = {s1.valid, s0.valid} & {2{enable_i & ~rst}};

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_req),
    .o_grant     (w_grant),
    .o_grant_src (w_grant_src),
    .o_any_grant (w_any_grant)
  );

  assign s0.ready = w_grant[0];
  assign s1.ready = w_grant[1];

  // Issue register: the granted pixel and its source travel together here,
  // so {conv_done_o, r_issue_src} is the entry point of the tag pipe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_red_o   <= '0;
      conv_green_o <= '0;
      conv_blue_o  <= '0;
      conv_done_o  <= 1'b0;
      r_issue_src  <= SRC_LEFT;
    end else begin
      conv_done_o <= w_any_grant;
      if (w_any_grant) begin
        r_issue_src <= w_grant_src;
        if (w_grant_src == SRC_RIGHT) begin
          conv_red_o   <= s1.red;
          conv_green_o <= s1.green;
          conv_blue_o  <= s1.blue;
        end else begin
          conv_red_o   <= s0.red;
          conv_green_o <= s0.green;
          conv_blue_o  <= s0.blue;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CONV_LATENCY; i++) begin
        r_tag[i] <= '0;
      end
    end else begin
      r_tag[0] <= '{valid: conv_done_o, src: r_issue_src};
      for (int i = 1; i < CONV_LATENCY; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  assign w_tail     = r_tag[CONV_LATENCY-1];
  assign w_collect  = conv_done_i & w_tail.valid;
  assign w_mismatch = conv_done_i ^ w_tail.valid;

  always_comb begin
    w_tags_busy = 1'b0;
    for (int i = 0; i < CONV_LATENCY; i++) begin
      w_tags_busy = w_tags_busy | r_tag[i].valid;
    end
  end

  assign idle_o = rst | ~(conv_done_o | w_tags_busy | w_any_grant);

  // Result collection, per-source frame counting and sticky protocol error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_o       <= '0;
      gray_valid_o <= 1'b0;
      gray_src_o   <= SRC_LEFT;
      frame_done_o <= 2'b00;
      err_o        <= 1'b0;
      r_cnt[0]     <= '0;
      r_cnt[1]     <= '0;
    end else begin
      gray_valid_o <= w_collect;
      frame_done_o <= 2'b00;
      if (w_mismatch) begin
        err_o <= 1'b1;
      end
      if (w_collect) begin
        gray_o     <= conv_gray_i;
        gray_src_o <= w_tail.src;
        if (r_cnt[w_tail.src] == c_last_pix) begin
          r_cnt[w_tail.src]        <= '0;
          frame_done_o[w_tail.src] <= 1'b1;
        end else begin
          r_cnt[w_tail.src] <= r_cnt[w_tail.src] + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gray_conv_sched.sv
// ============================================================================
// Module   : tb_gray_conv_sched
// Brief    : Directed table-driven bench for gray_conv_sched with an rgb2gray model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gray_conv_sched;
  import gray_sched_pkg::*;

  localparam int LAT = 1;
  localparam int FP  = 4;
  localparam int CW  = 3;

  localparam logic [23:0] PZ = 24'h000000;
  localparam logic [23:0] P0 = 24'h246A90;  // gray 0x59
  localparam logic [23:0] P1 = 24'hFFFFFF;  // gray 0xFF
  localparam logic [23:0] P2 = 24'h102030;  // gray 0x1D
  localparam logic [23:0] P3 = 24'h000000;  // gray 0x00
  localparam logic [23:0] P4 = 24'h800000;  // gray 0x26

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic enable_i = 1'b0;
  logic force_done = 1'b0;

  gray_conv_sched_if s0_if ();
  gray_conv_sched_if s1_if ();

  logic [7:0] conv_red_o, conv_green_o, conv_blue_o, conv_gray_i, gray_o;
  logic       conv_done_o, conv_done_i, gray_valid_o, gray_src_o, idle_o, err_o;
  logic [1:0] frame_done_o;
  logic       m_done;
  logic [7:0] m_gray;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  gray_conv_sched #(.CONV_LATENCY(LAT), .FRAME_PIXELS(FP), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable_i     (enable_i),
    .s0           (s0_if),
    .s1           (s1_if),
    .conv_red_o   (conv_red_o),
    .conv_green_o (conv_green_o),
    .conv_blue_o  (conv_blue_o),
    .conv_done_o  (conv_done_o),
    .conv_gray_i  (conv_gray_i),
    .conv_done_i  (conv_done_i),
    .gray_o       (gray_o),
    .gray_valid_o (gray_valid_o),
    .gray_src_o   (gray_src_o),
    .frame_done_o (frame_done_o),
    .idle_o       (idle_o),
    .err_o        (err_o)
  );

  function automatic logic [7:0] rgb2gray(input logic [7:0] r, input logic [7:0] g,
                                          input logic [7:0] b);
    logic [17:0] acc;
    acc = 18'd77 * r + 18'd150 * g + 18'd29 * b;
    return acc[15:8];
  endfunction

  // Single-stage rgb2gray model sharing the DUT reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_done <= 1'b0;
      m_gray <= 8'h00;
    end else begin
      m_done <= conv_done_o;
      m_gray <= rgb2gray(conv_red_o, conv_green_o, conv_blue_o);
    end
  end

  assign conv_done_i = m_done | force_done;
  assign conv_gray_i = m_gray;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [23:0] p0, input logic v1,
                       input logic [23:0] p1);
    s0_if.valid = v0;
    {s0_if.red, s0_if.green, s0_if.blue} = p0;
    s1_if.valid = v1;
    {s1_if.red, s1_if.green, s1_if.blue} = p1;
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        v0;
    logic        v1;
    logic [23:0] p0;
    logic [23:0] p1;
    logic [1:0]  rdy;
    logic        cd;
    logic        gv;
    logic        src;
    logic [7:0]  gray;
    logic [1:0]  fd;
    logic        idle;
  } vec_t;

  vec_t tbl [24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int emis;
    drive(1'b0, PZ, 1'b0, PZ);

    //           rst en v0 v1 p0  p1  rdy   cd gv src gray   fd    idle
    tbl[0]  = '{0, 1, 1, 0, P0, PZ, 2'b01, 0, 0, 0, 8'h00, 2'b00, 0};
    tbl[1]  = '{0, 1, 0, 0, PZ, PZ, 2'b00, 1, 0, 0, 8'h00, 2'b00, 0};
    tbl[2]  = '{0, 1, 0, 0, PZ, PZ, 2'b00, 0, 0, 0, 8'h00, 2'b00, 0};
    tbl[3]  = '{0, 1, 0, 0, PZ, PZ, 2'b00, 0, 1, 0, 8'h59, 2'b00, 1};
    tbl[4]  = '{1, 1, 0, 0, PZ, PZ, 2'b00, 0, 0, 0, 8'h00, 2'b00, 1};
    tbl[5]  = '{0, 1, 1, 1, P2, P1, 2'b01, 0, 0, 0, 8'h00, 2'b00, 0};
    tbl[6]  = '{0, 1, 1, 1, P2, P1, 2'b10, 1, 0, 0, 8'h00, 2'b00, 0};
    tbl[7]  = '{0, 1, 1, 1, P2, P1, 2'b01, 1, 0, 0, 8'h00, 2'b00, 0};
    tbl[8]  = '{0, 1, 1, 1, P2, P1, 2'b10, 1, 1, 0, 8'h1D, 2'b00, 0};
    tbl[9]  = '{0, 1, 1, 1, P2, P1, 2'b01, 1, 1, 1, 8'hFF, 2'b00, 0};
    tbl[10] = '{0, 1, 1, 1, P2, P1, 2'b10, 1, 1, 0, 8'h1D, 2'b00, 0};
    tbl[11] = '{0, 1, 1, 1, P2, P1, 2'b01, 1, 1, 1, 8'hFF, 2'b00, 0};
    tbl[12] = '{0, 1, 1, 1, P2, P1, 2'b10, 1, 1, 0, 8'h1D, 2'b00, 0};
    tbl[13] = '{0, 0, 1, 1, P2, P1, 2'b00, 1, 1, 1, 8'hFF, 2'b00, 0};
    tbl[14] = '{0, 0, 1, 1, P2, P1, 2'b00, 0, 1, 0, 8'h1D, 2'b01, 0};
    tbl[15] = '{0, 0, 1, 1, P2, P1, 2'b00, 0, 1, 1, 8'hFF, 2'b10, 1};
    tbl[16] = '{0, 0, 1, 1, P2, P1, 2'b00, 0, 0, 0, 8'h00, 2'b00, 1};
    tbl[17] = '{0, 0, 1, 1, P2, P1, 2'b00, 0, 0, 0, 8'h00, 2'b00, 1};
    tbl[18] = '{0, 1, 0, 1, PZ, P4, 2'b10, 0, 0, 0, 8'h00, 2'b00, 0};
    tbl[19] = '{0, 1, 1, 1, P3, P4, 2'b01, 1, 0, 0, 8'h00, 2'b00, 0};
    tbl[20] = '{0, 1, 1, 1, P3, P4, 2'b10, 1, 0, 0, 8'h00, 2'b00, 0};
    tbl[21] = '{0, 1, 0, 0, PZ, PZ, 2'b00, 1, 1, 1, 8'h26, 2'b00, 0};
    tbl[22] = '{0, 1, 0, 0, PZ, PZ, 2'b00, 0, 1, 0, 8'h00, 2'b00, 0};
    tbl[23] = '{0, 1, 0, 0, PZ, PZ, 2'b00, 0, 1, 1, 8'h26, 2'b00, 1};

    // Reset state
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    check("reset idle", idle_o, 1);
    check("reset gray_valid", gray_valid_o, 0);
    check("reset conv_done", conv_done_o, 0);
    check("reset err", err_o, 0);
    check("reset frame_done", frame_done_o, 2'b00);
    check("reset gray", gray_o, 8'h00);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      rst      = tbl[i].rst;
      enable_i = tbl[i].en;
      drive(tbl[i].v0, tbl[i].p0, tbl[i].v1, tbl[i].p1);
      #1;
      check($sformatf("row%0d ready", i), {s1_if.ready, s0_if.ready}, tbl[i].rdy);
      check($sformatf("row%0d conv_done", i), conv_done_o, tbl[i].cd);
      check($sformatf("row%0d gray_valid", i), gray_valid_o, tbl[i].gv);
      check($sformatf("row%0d frame_done", i), frame_done_o, tbl[i].fd);
      check($sformatf("row%0d idle", i), idle_o, tbl[i].idle);
      check($sformatf("row%0d err", i), err_o, 0);
      if (tbl[i].gv) begin
        check($sformatf("row%0d gray_src", i), gray_src_o, tbl[i].src);
        check($sformatf("row%0d gray", i), gray_o, tbl[i].gray);
      end
    end

    // Frame wrap: 9 pixels from source 1 only, FRAME_PIXELS=4
    @(negedge clk); rst = 1'b1; drive(1'b0, PZ, 1'b0, PZ);
    @(negedge clk); rst = 1'b0; enable_i = 1'b1;
    emis = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive(1'b0, PZ, (c < 9), P1);
      #1;
      if (gray_valid_o) begin
        emis++;
        check($sformatf("wrap src e%0d", emis), gray_src_o, 1);
        check($sformatf("wrap frame_done e%0d", emis), frame_done_o,
              (emis == 4 || emis == 8) ? 2'b10 : 2'b00);
      end else begin
        check($sformatf("wrap frame_done idle c%0d", c), frame_done_o, 2'b00);
      end
    end
    check("wrap emission count", emis, 9);
    check("wrap err", err_o, 0);

    // Protocol error: converter done with nothing in flight
    @(negedge clk); rst = 1'b1; enable_i = 1'b0; drive(1'b0, PZ, 1'b0, PZ);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); force_done = 1'b1;
    #1 check("perr before edge", err_o, 0);
    @(negedge clk); force_done = 1'b0;
    #1;
    check("perr set", err_o, 1);
    check("perr no gray_valid", gray_valid_o, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      check($sformatf("perr sticky c%0d", c), err_o, 1);
      check($sformatf("perr gray_valid c%0d", c), gray_valid_o, 0);
    end
    @(negedge clk); rst = 1'b1;
    #1 check("perr cleared by rst", err_o, 0);

    // Async reset mid-burst from source 0
    @(negedge clk); rst = 1'b0; enable_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      drive(1'b1, P2, 1'b0, PZ);
    end
    #1 check("burst gray_valid before rst", gray_valid_o, 1);
    #1 rst = 1'b1;
    drive(1'b1, P2, 1'b1, P1);
    #1;
    check("arst gray_valid", gray_valid_o, 0);
    check("arst conv_done", conv_done_o, 0);
    check("arst conv_rgb", {conv_red_o, conv_green_o, conv_blue_o}, 24'h0);
    check("arst gray", gray_o, 8'h00);
    check("arst frame_done", frame_done_o, 2'b00);
    check("arst idle", idle_o, 1);
    check("arst ready", {s1_if.ready, s0_if.ready}, 2'b00);
    @(negedge clk); rst = 1'b0;
    #1 check("post-rst pointer", {s1_if.ready, s0_if.ready}, 2'b01);
    emis = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      drive((c < 3), P2, 1'b0, PZ);
      #1;
      if (gray_valid_o) begin
        emis++;
        check($sformatf("restart frame_done e%0d", emis), frame_done_o,
              (emis == 4) ? 2'b01 : 2'b00);
      end
    end
    check("restart emission count", emis, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
